// File: rtl/usb_tx_scheduler.sv
// Shares the USB transmit serializer between the handshake responder and the data endpoint:
// arbitrates, issues the start pulse and byte handshake, waits out EOP and enforces the inter-packet gap.
module usb_tx_scheduler #(
    parameter int unsigned IPG_CYCLES    = 4,
    parameter int unsigned START_TIMEOUT = 32
) (
    input  logic       clk12,
    input  logic       RST_N,
    input  logic       hsReq,
    input  logic [3:0] hsPid,
    output logic       hsDone,
    input  logic       dReq,
    input  logic [3:0] dPid,
    input  logic       dZeroLen,
    input  logic [7:0] dByte,
    input  logic       dByteValid,
    input  logic       dByteLast,
    output logic       dByteAck,
    output logic       dDone,
    output logic       reqSendPacket,
    input  logic       txAcceptNewData,
    output logic [7:0] txData,
    output logic       txDataValid,
    output logic       txIsLastByte,
    input  logic       sending,
    output logic       busy,
    output logic       abortErr
);

    localparam int unsigned TO_W  = 8;
    localparam int unsigned GAP_W = 4;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IPG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_PID, S_PAYLOAD, S_WAIT_ON, S_WAIT_OFF, S_GAP
    } state_e;

    typedef enum logic {OWN_HS, OWN_DATA} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [3:0]       pid_q, pid_d;
    logic             last_q, last_d;
    logic             saw_q, saw_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             hs_done_q, hs_done_d;
    logic             d_done_q, d_done_d;
    logic             abort_q, abort_d;

    logic             in_pid_c;
    logic             pay_valid_c;
    logic             finish_c;
    logic [TO_W-1:0]  tcnt_inc_c;
    state_e           after_last_c;

    assign in_pid_c    = (state_q == S_START) || (state_q == S_PID);
    assign pay_valid_c = (state_q == S_PAYLOAD) && dByteValid;
    assign tcnt_inc_c  = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
    // A short packet may already have raised sending; skip straight to waiting for it to fall.
    assign after_last_c = (saw_q || sending) ? S_WAIT_OFF : S_WAIT_ON;

    assign reqSendPacket = (state_q == S_START);
    assign txDataValid   = in_pid_c || pay_valid_c;
    assign txData        = in_pid_c ? {~pid_q, pid_q} : (pay_valid_c ? dByte : 8'h00);
    assign txIsLastByte  = in_pid_c ? last_q : (pay_valid_c && dByteLast);
    assign dByteAck      = pay_valid_c && txAcceptNewData;
    assign busy          = (state_q != S_IDLE);
    assign hsDone        = hs_done_q;
    assign dDone         = d_done_q;
    assign abortErr      = abort_q;

    // Next-state and counter logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        pid_d    = pid_q;
        last_d   = last_q;
        saw_d    = saw_q;
        tcnt_d   = tcnt_q;
        gcnt_d   = gcnt_q;
        abort_d  = 1'b0;
        finish_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (hsReq || dReq) begin
                    owner_d = hsReq ? OWN_HS : OWN_DATA;
                    pid_d   = hsReq ? hsPid : dPid;
                    last_d  = hsReq || dZeroLen;
                    saw_d   = 1'b0;
                    tcnt_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = tcnt_inc_c;
                saw_d   = saw_q || sending;
                state_d = S_PID;
            end
            S_PID: begin
                tcnt_d = tcnt_inc_c;
                saw_d  = saw_q || sending;
                if (txAcceptNewData) begin
                    state_d = last_q ? after_last_c : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                tcnt_d = tcnt_inc_c;
                saw_d  = saw_q || sending;
                if (dByteAck && dByteLast) begin
                    state_d = after_last_c;
                end
            end
            S_WAIT_ON: begin
                if (sending) begin
                    state_d = S_WAIT_OFF;
                end else if (tcnt_q >= TO_LAST) begin
                    abort_d  = 1'b1;
                    finish_c = 1'b1;
                    gcnt_d   = '0;
                    state_d  = S_GAP;
                end else begin
                    tcnt_d = tcnt_inc_c;
                end
            end
            S_WAIT_OFF: begin
                if (!sending) begin
                    finish_c = 1'b1;
                    gcnt_d   = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        hs_done_d = finish_c && (owner_q == OWN_HS);
        d_done_d  = finish_c && (owner_q == OWN_DATA);
    end

    always_ff @(posedge clk12 or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_HS;
            pid_q     <= '0;
            last_q    <= 1'b0;
            saw_q     <= 1'b0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            hs_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            pid_q     <= pid_d;
            last_q    <= last_d;
            saw_q     <= saw_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            hs_done_q <= hs_done_d;
            d_done_q  <= d_done_d;
            abort_q   <= abort_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler with a small transmitter/requester model and transfer log.
module tb_usb_tx_scheduler;

    localparam int IPG = 4;
    localparam int TMO = 32;

    logic       clk12 = 1'b0;
    logic       RST_N = 1'b0;
    logic       hsReq = 1'b0;
    logic [3:0] hsPid = 4'h0;
    logic       hsDone;
    logic       dReq = 1'b0;
    logic [3:0] dPid = 4'h0;
    logic       dZeroLen = 1'b0;
    logic [7:0] dByte = 8'h00;
    logic       dByteValid = 1'b0;
    logic       dByteLast = 1'b0;
    logic       dByteAck;
    logic       dDone;
    logic       reqSendPacket;
    logic       txAcceptNewData = 1'b0;
    logic [7:0] txData;
    logic       txDataValid;
    logic       txIsLastByte;
    logic       sending = 1'b0;
    logic       busy;
    logic       abortErr;

    usb_tx_scheduler #(.IPG_CYCLES(IPG), .START_TIMEOUT(TMO)) dut (
        .clk12(clk12), .RST_N(RST_N),
        .hsReq(hsReq), .hsPid(hsPid), .hsDone(hsDone),
        .dReq(dReq), .dPid(dPid), .dZeroLen(dZeroLen),
        .dByte(dByte), .dByteValid(dByteValid), .dByteLast(dByteLast),
        .dByteAck(dByteAck), .dDone(dDone),
        .reqSendPacket(reqSendPacket), .txAcceptNewData(txAcceptNewData),
        .txData(txData), .txDataValid(txDataValid), .txIsLastByte(txIsLastByte),
        .sending(sending), .busy(busy), .abortErr(abortErr)
    );

    always #5 clk12 = ~clk12;

    int cyc = 0;
    always @(posedge clk12) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Transmitter model knobs: sending high for tx_send_len cycles starting tx_send_dly after START
    // (tx_send_dly == 0 means sending never rises); accept re-rises tx_acc_off cycles after a transfer.
    int tx_send_dly = 3;
    int tx_send_len = 10;
    int tx_acc_off  = 8;

    logic       d_active = 1'b0;
    int         plen = 0;
    int         pidx = 0;
    logic [7:0] pay [4];

    int         req_q [$];
    int         fall_q [$];
    logic [7:0] xd_q [$];
    logic       xl_q [$];
    int ack_cnt = 0, hs_done_cnt = 0, d_done_cnt = 0, abort_cnt = 0;
    int hs_done_cyc = 0, d_done_cyc = 0, abort_cyc = 0, idle_cyc = 0;

    logic m_armed = 1'b0, m_got_last = 1'b0, m_xfer, m_acc_n, m_send_n;
    logic m_prev_busy = 1'b0, m_prev_send = 1'b0;
    int   m_since = 0, m_acc_wait = 0;

    // Sample at negedge, apply model outputs 1 time unit after the next posedge.
    initial begin
        forever begin
            @(negedge clk12);
            if (!RST_N) m_armed = 1'b0;
            if (reqSendPacket) begin
                req_q.push_back(cyc);
                m_armed = 1'b1; m_since = 0; m_got_last = 1'b0; m_acc_wait = 0;
            end else if (m_armed) begin
                m_since++;
            end
            m_xfer = txDataValid && txAcceptNewData;
            if (m_xfer) begin
                xd_q.push_back(txData);
                xl_q.push_back(txIsLastByte);
                if (txIsLastByte) m_got_last = 1'b1;
                m_acc_wait = tx_acc_off;
            end else if (m_acc_wait > 0) begin
                m_acc_wait--;
            end
            if (dByteAck) begin ack_cnt++; pidx++; end
            if (hsDone)   begin hs_done_cnt++; hs_done_cyc = cyc; end
            if (dDone)    begin d_done_cnt++;  d_done_cyc  = cyc; end
            if (abortErr) begin abort_cnt++;   abort_cyc   = cyc; end
            if (m_prev_busy && !busy) idle_cyc = cyc;
            m_prev_busy = busy;
            if (m_prev_send && !sending) fall_q.push_back(cyc);
            m_prev_send = sending;
            m_acc_n  = m_armed && !m_got_last && !m_xfer && (m_acc_wait == 0);
            m_send_n = m_armed && (tx_send_dly > 0) && (m_since + 1 >= tx_send_dly) &&
                       (m_since + 1 < tx_send_dly + tx_send_len);
            @(posedge clk12);
            #1;
            txAcceptNewData = m_acc_n;
            sending         = m_send_n;
            dByteValid      = d_active && (pidx < plen);
            dByte           = dByteValid ? pay[pidx] : 8'h00;
            dByteLast       = dByteValid && (pidx == plen - 1);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk12);
            #2;
        end
    endtask

    // sel: 0 hsDone, 1 dDone, 2 busy low, 3 dByteAck
    task automatic wait_for(input int sel, input int budget, input string tag);
        logic hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk12);
            case (sel)
                0:       hit = hsDone;
                1:       hit = dDone;
                2:       hit = !busy;
                default: hit = dByteAck;
            endcase
        end
        if (!hit) check_eq({tag, "_timeout"}, 32'(hit), 32'd1);
    endtask

    task automatic clear_log();
        req_q.delete(); fall_q.delete(); xd_q.delete(); xl_q.delete();
        ack_cnt = 0; hs_done_cnt = 0; d_done_cnt = 0; abort_cnt = 0;
        hs_done_cyc = 0; d_done_cyc = 0; abort_cyc = 0; idle_cyc = 0;
        pidx = 0;
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [7:0] exp_b [4],
                               input logic [3:0] exp_l);
        check_eq({tag, "_count"}, 32'(xd_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_byte"}, (i < xd_q.size()) ? 32'(xd_q[i]) : 32'hFFFF, 32'(exp_b[i]));
            check_eq({tag, "_last"}, (i < xl_q.size()) ? 32'(xl_q[i]) : 32'hFFFF, 32'(exp_l[i]));
        end
    endtask

    logic [7:0] eb [4];

    initial begin
        tick(2);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(txDataValid), 32'd0);
        check_eq("rst_data", 32'(txData), 32'd0);
        check_eq("rst_req", 32'(reqSendPacket), 32'd0);
        check_eq("rst_dones", 32'({hsDone, dDone, abortErr, dByteAck, txIsLastByte}), 32'd0);
        RST_N = 1'b1;
        tick(2);

        // Handshake packet, sending high 3..12 cycles after START
        clear_log();
        tx_send_dly = 3; tx_send_len = 10;
        hsPid = 4'h2; hsReq = 1'b1;
        wait_for(0, 100, "hs1_done");
        tick(); hsReq = 1'b0;
        wait_for(2, 50, "hs1_idle");
        tick();
        eb = '{8'hD2, 8'h00, 8'h00, 8'h00};
        check_bytes("hs1", 1, eb, 4'b0001);
        check_eq("hs1_reqs", 32'(req_q.size()), 32'd1);
        check_eq("hs1_done_cnt", 32'(hs_done_cnt), 32'd1);
        check_eq("hs1_done_after_fall", (fall_q.size() > 0) ? 32'(hs_done_cyc - fall_q[0]) : 32'hFFFF, 32'd1);
        check_eq("hs1_done_after_start", (req_q.size() > 0) ? 32'(hs_done_cyc - req_q[0]) : 32'hFFFF, 32'd14);
        check_eq("hs1_gap", 32'(idle_cyc - hs_done_cyc), 32'(IPG));
        check_eq("hs1_abort", 32'(abort_cnt), 32'd0);

        // Data packet with three payload bytes, accept re-rising every 9 cycles
        clear_log();
        tx_send_len = 40;
        pay = '{8'h11, 8'h22, 8'h33, 8'h00}; plen = 3;
        dPid = 4'h3; dZeroLen = 1'b0; d_active = 1'b1; dReq = 1'b1;
        wait_for(1, 200, "d2_done");
        tick(); dReq = 1'b0; d_active = 1'b0;
        wait_for(2, 50, "d2_idle");
        tick();
        eb = '{8'hC3, 8'h11, 8'h22, 8'h33};
        check_bytes("d2", 4, eb, 4'b1000);
        check_eq("d2_acks", 32'(ack_cnt), 32'd3);
        check_eq("d2_done_cnt", 32'(d_done_cnt), 32'd1);
        check_eq("d2_hs_done_cnt", 32'(hs_done_cnt), 32'd0);
        check_eq("d2_reqs", 32'(req_q.size()), 32'd1);

        // Zero-length data packet
        clear_log();
        tx_send_len = 10;
        plen = 0; dZeroLen = 1'b1; dPid = 4'hB; d_active = 1'b1; dReq = 1'b1;
        wait_for(1, 100, "z3_done");
        tick(); dReq = 1'b0; dZeroLen = 1'b0; d_active = 1'b0;
        wait_for(2, 50, "z3_idle");
        tick();
        eb = '{8'h4B, 8'h00, 8'h00, 8'h00};
        check_bytes("z3", 1, eb, 4'b0001);
        check_eq("z3_acks", 32'(ack_cnt), 32'd0);
        check_eq("z3_done_cnt", 32'(d_done_cnt), 32'd1);

        // Simultaneous requests: handshake first, data after the gap
        clear_log();
        pay = '{8'h5C, 8'h00, 8'h00, 8'h00}; plen = 1;
        hsPid = 4'hA; dPid = 4'h3; d_active = 1'b1;
        hsReq = 1'b1; dReq = 1'b1;
        wait_for(0, 100, "s4_hs_done");
        tick(); hsReq = 1'b0;
        wait_for(1, 200, "s4_d_done");
        tick(); dReq = 1'b0; d_active = 1'b0;
        wait_for(2, 50, "s4_idle");
        tick();
        eb = '{8'h5A, 8'hC3, 8'h5C, 8'h00};
        check_bytes("s4", 3, eb, 4'b0101);
        check_eq("s4_reqs", 32'(req_q.size()), 32'd2);
        check_eq("s4_ipg", (req_q.size() > 1 && fall_q.size() > 0) ?
                 32'(req_q[1] - fall_q[0] >= IPG) : 32'd0, 32'd1);
        check_eq("s4_hs_before_d", (req_q.size() > 1) ? 32'(hs_done_cyc < req_q[1]) : 32'd0, 32'd1);
        check_eq("s4_dones", 32'({hs_done_cnt[3:0], d_done_cnt[3:0]}), 32'h11);

        // sending never rises: timeout abort
        clear_log();
        tx_send_dly = 0;
        hsPid = 4'h2; hsReq = 1'b1;
        wait_for(0, 100, "t5_done");
        tick(); hsReq = 1'b0;
        wait_for(2, 50, "t5_idle");
        tick();
        check_eq("t5_abort_cnt", 32'(abort_cnt), 32'd1);
        check_eq("t5_abort_time", (req_q.size() > 0) ? 32'(abort_cyc - req_q[0]) : 32'hFFFF, 32'(TMO));
        check_eq("t5_done_with_abort", 32'(hs_done_cyc), 32'(abort_cyc));
        check_eq("t5_hs_done_cnt", 32'(hs_done_cnt), 32'd1);
        check_eq("t5_gap", 32'(idle_cyc - abort_cyc), 32'(IPG));
        tx_send_dly = 3;

        // Reset asserted during the payload phase
        clear_log();
        tx_send_len = 40;
        pay = '{8'h11, 8'h22, 8'h33, 8'h00}; plen = 3;
        dPid = 4'h3; d_active = 1'b1; dReq = 1'b1;
        wait_for(3, 100, "r6_ack");
        tick();
        check_eq("r6_busy_before", 32'(busy), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        check_eq("r6_busy", 32'(busy), 32'd0);
        check_eq("r6_valid", 32'(txDataValid), 32'd0);
        check_eq("r6_data", 32'(txData), 32'd0);
        check_eq("r6_outs", 32'({reqSendPacket, dByteAck, dDone, hsDone, abortErr, txIsLastByte}), 32'd0);
        dReq = 1'b0; d_active = 1'b0;
        tick(3);
        RST_N = 1'b1;
        tick(60);
        check_eq("r6_no_done", 32'(d_done_cnt + hs_done_cnt + abort_cnt), 32'd0);
        clear_log();
        tx_send_len = 10;
        hsPid = 4'hE; hsReq = 1'b1;
        wait_for(0, 100, "r6_hs_done");
        tick(); hsReq = 1'b0;
        wait_for(2, 50, "r6_idle");
        tick();
        eb = '{8'h1E, 8'h00, 8'h00, 8'h00};
        check_bytes("r6_hs", 1, eb, 4'b0001);
        check_eq("r6_hs_done_cnt", 32'(hs_done_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Sequences and shares the USB transmit serializer between two requesters: the handshake responder (single-byte ACK/NAK/STALL packets) and the data endpoint (PID + payload byte stream).
- Issues the transmitter's send request and byte handshake.
- Guarantees exactly one byte transfer per accept phase.
- Waits out end-of-packet, then enforces an inter-packet gap before the next grant.

Parameters:
- IPG_CYCLES, 4: idle clk12 cycles after sending falls before a new packet may start (1..15).
- START_TIMEOUT, 32: clk12 cycles to wait for sending to rise before aborting (2..255).

Ports:
- clk12  in  1  12 MHz transmit clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- hsReq  in  1  handshake requester wants to send; held until hsDone.
- hsPid  in  4  handshake PID (low nibble); stable while hsReq.
- hsDone  out  1  one-cycle pulse: handshake packet finished or aborted.
- dReq  in  1  data requester wants to send; held until dDone.
- dPid  in  4  DATA0/DATA1 PID nibble; stable while dReq.
- dZeroLen  in  1  packet has no payload; PID is the last byte.
- dByte  in  8  payload byte.
- dByteValid  in  1  dByte valid.
- dByteLast  in  1  dByte is the final payload byte.
- dByteAck  out  1  payload byte consumed this cycle.
- dDone  out  1  one-cycle pulse: data packet finished or aborted.
- reqSendPacket  out  1  start pulse to the transmitter.
- txAcceptNewData  in  1  transmitter byte buffer empty.
- txData  out  8  byte to the transmitter.
- txDataValid  out  1  txData valid.
- txIsLastByte  out  1  txData is the packet's last byte.
- sending  in  1  transmitter is on the line.
- busy  out  1  scheduler not IDLE.
- abortErr  out  1  one-cycle pulse: START_TIMEOUT expired.

Behaviour:
- Reset: state IDLE; all outputs 0; gap counter 0; owner register HS.
- States: IDLE, START, PID, PAYLOAD, WAIT_ON, WAIT_OFF, GAP.
- IDLE arbitration:
  - If hsReq, set owner=HS; else if dReq, set owner=DATA.
  - Handshake has fixed priority. Owner is latched until DONE; requests arriving mid-packet wait.
  - On grant, go to START.
- START (1 cycle):
  - reqSendPacket=1; txData={~pid,pid}; txDataValid=1.
  - txIsLastByte = (owner==HS) | dZeroLen. Go to PID.
- PID:
  - Hold txData/txDataValid/txIsLastByte.
  - Byte is taken on the edge where txDataValid & txAcceptNewData.
  - Then go to WAIT_ON if last, else PAYLOAD.
- PAYLOAD:
  - txData=dByte, txDataValid=dByteValid, txIsLastByte=dByteLast, dByteAck=dByteValid & txAcceptNewData (combinational).
  - An acked byte with dByteLast goes to WAIT_ON.
  - The transmitter drops accept the cycle after a transfer, so no byte is consumed twice.
  - dByteValid low means no transfer; the state is held (underrun is the requester's fault; no recovery).
- WAIT_ON:
  - Counts cycles from START; sending=1 goes to WAIT_OFF.
  - Counter reaching START_TIMEOUT: pulse abortErr and owner's done, go to GAP.
  - If sending rose before entering WAIT_ON (short packet), WAIT_ON is skipped via a latched sawSending flag set in START/PID/PAYLOAD.
- WAIT_OFF:
  - When sending=0, pulse owner's done (hsDone or dDone) and go to GAP.
- GAP:
  - Counts IPG_CYCLES cycles, then goes to IDLE.
  - Requests seen during GAP are not granted until IDLE.
- busy = (state != IDLE).
- txDataValid=0 in IDLE/WAIT_*/GAP; txData=0 when not valid.
- Counters saturate and never wrap.
- Simultaneous hsReq & dReq in IDLE: HS wins. DATA is granted after HS's GAP if dReq is still held.
- RST_N asserted mid-packet: immediate return to reset values. The transmitter finishes on its own; no done pulse is issued.

Test Plan:
- hsReq=1, hsPid=4'h2; sending rises 3 cycles later, falls 10 cycles later. Required: one reqSendPacket pulse; txData=8'hD2 with txIsLastByte=1; exactly one transfer; hsDone one cycle after sending falls; IDLE after 4 GAP cycles.
- dReq, dPid=4'h3, payload 8'h11,8'h22,8'h33 (last), accept toggling every 8 cycles. Required: transfer order C3,11,22,33; txIsLastByte only on 33; three dByteAck pulses; one dDone.
- dReq with dZeroLen=1, dPid=4'hB. Required: single byte 8'h4B with txIsLastByte=1; no dByteAck.
- hsReq and dReq asserted in the same cycle. Required: handshake sent first; data START occurs ≥ IPG_CYCLES after sending falls.
- sending never rises. Required: abortErr and hsDone pulse START_TIMEOUT cycles after START; busy drops after GAP.
- RST_N low during PAYLOAD. Required: all outputs 0 asynchronously, no done pulse; after release, a fresh hsReq is served normally.
